// File: rtl/stack_base_alu.sv
// stack_base_alu
//   LIFO stack of signed N-bit words with ADD/MUL on the top two entries.
//   One 3-bit opcode is executed per rising clock edge; results and popped
//   values appear on a registered output together with a signed-overflow flag.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   input_data   signed word written by PUSH
//   opcode       100 ADD, 101 MUL, 110 PUSH, 111 POP, anything else NOP
//   output_data  registered result / popped value
//   overflow     registered signed-overflow flag of the last arithmetic op
//   empty        high when the stack holds no entries
//   full         high when the stack holds DEPTH entries
module stack_base_alu #(
  parameter int N     = 8,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [N-1:0] input_data,
  input  logic        [2:0]   opcode,
  output logic signed [N-1:0] output_data,
  output logic                overflow,
  output logic                empty,
  output logic                full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  // Signed add overflows when both operands share a sign the sum does not.
  function automatic logic add_ovf(input logic signed [N-1:0] a,
                                   input logic signed [N-1:0] b,
                                   input logic signed [N-1:0] s);
    add_ovf = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  // Product fits in N signed bits only if its upper N+1 bits are a pure sign
  // extension (all ones or all zeros).
  function automatic logic mul_ovf(input logic signed [2*N-1:0] p);
    mul_ovf = !((&p[2*N-1:N-1]) || (~|p[2*N-1:N-1]));
  endfunction

  logic signed [N-1:0]   mem_r [DEPTH];
  logic        [CW-1:0]  count_r;
  logic signed [N-1:0]   out_r;
  logic                  ovf_r;

  logic        [CW-1:0]  count_nxt_s;
  logic signed [N-1:0]   out_nxt_s;
  logic                  ovf_nxt_s;
  logic                  wr_en_s;
  logic        [CW-1:0]  top_cnt_s;
  logic        [CW-1:0]  sec_cnt_s;
  logic        [IW-1:0]  top_idx_s;
  logic        [IW-1:0]  sec_idx_s;
  logic        [IW-1:0]  wr_idx_s;
  logic signed [N-1:0]   top_s;
  logic signed [N-1:0]   second_s;
  logic signed [N-1:0]   sum_s;
  logic signed [2*N-1:0] prod_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  two_s;

  assign empty_s = (count_r == CW'(0));
  assign full_s  = (count_r == CW'(DEPTH));
  assign two_s   = (count_r >= CW'(2));

  // Indices wrap when count is small; the reads are only used when guarded.
  assign top_cnt_s = count_r - CW'(1);
  assign sec_cnt_s = count_r - CW'(2);
  assign top_idx_s = top_cnt_s[IW-1:0];
  assign sec_idx_s = sec_cnt_s[IW-1:0];
  assign wr_idx_s  = count_r[IW-1:0];

  assign top_s    = mem_r[top_idx_s];
  assign second_s = mem_r[sec_idx_s];
  assign sum_s    = second_s + top_s;
  assign prod_s   = (2*N)'(second_s) * (2*N)'(top_s);

  // Next-state decode for count, output register, overflow flag and write.
  always_comb begin
    count_nxt_s = count_r;
    out_nxt_s   = out_r;
    ovf_nxt_s   = ovf_r;
    wr_en_s     = 1'b0;
    case (opcode)
      OP_ADD: begin
        if (two_s) begin
          out_nxt_s = sum_s;
          ovf_nxt_s = add_ovf(second_s, top_s, sum_s);
        end else begin
          ovf_nxt_s = 1'b0;
        end
      end
      OP_MUL: begin
        if (two_s) begin
          out_nxt_s = prod_s[N-1:0];
          ovf_nxt_s = mul_ovf(prod_s);
        end else begin
          ovf_nxt_s = 1'b0;
        end
      end
      OP_PUSH: begin
        ovf_nxt_s = 1'b0;
        if (!full_s) begin
          wr_en_s     = 1'b1;
          count_nxt_s = count_r + CW'(1);
        end else begin
          wr_en_s     = 1'b0;
        end
      end
      OP_POP: begin
        ovf_nxt_s = 1'b0;
        if (!empty_s) begin
          out_nxt_s   = top_s;
          count_nxt_s = top_cnt_s;
        end else begin
          count_nxt_s = count_r;
        end
      end
      // 000-011 and any X/Z opcode: hold everything.
      default: begin
        count_nxt_s = count_r;
        out_nxt_s   = out_r;
        ovf_nxt_s   = ovf_r;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CW'(0);
      out_r   <= N'(0);
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      out_r   <= out_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Stack storage; cleared on reset, written only by an accepted PUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= N'(0);
      end
    end else if (wr_en_s) begin
      mem_r[wr_idx_s] <= input_data;
    end else begin
      mem_r[wr_idx_s] <= mem_r[wr_idx_s];
    end
  end

  assign output_data = out_r;
  assign overflow    = ovf_r;
  assign empty       = empty_s;
  assign full        = full_s;

endmodule

// File: tb/tb_stack_base_alu.sv
module tb_stack_base_alu;

  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] MUL  = 3'b101;
  localparam logic [2:0] PUSH = 3'b110;
  localparam logic [2:0] POP  = 3'b111;

  logic              clk;
  logic              rst_n;
  logic signed [7:0] input_data;
  logic        [2:0] opcode;
  logic signed [7:0] output_data;
  logic              overflow;
  logic              empty;
  logic              full;

  int checks;
  int failures;

  typedef struct {
    string             name;
    logic signed [7:0] dout;
    logic              ovf;
    logic              emp;
    logic              ful;
  } exp_t;

  exp_t exp_q[$];

  stack_base_alu #(.N(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .input_data(input_data), .opcode(opcode),
    .output_data(output_data), .overflow(overflow), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.name, ".data"},  int'(output_data), int'(e.dout));
    chk({e.name, ".ovf"},   int'(overflow),    int'(e.ovf));
    chk({e.name, ".empty"}, int'(empty),       int'(e.emp));
    chk({e.name, ".full"},  int'(full),        int'(e.ful));
  endtask

  // Drive one opcode before the next rising edge and queue the expected result.
  task automatic op(input string name, input logic [2:0] opc, input int din,
                    input int dout, input bit ovf, input bit emp, input bit ful);
    exp_t e;
    @(negedge clk);
    opcode     = opc;
    input_data = 8'(din);
    e.name = name; e.dout = 8'(dout); e.ovf = ovf; e.emp = emp; e.ful = ful;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge after which a result is owed, compare it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_all(e);
    end
  end

  initial begin
    exp_t r;
    checks = 0; failures = 0;
    rst_n = 1'b0; opcode = 3'b000; input_data = 8'sd0;
    #12;
    r.name = "reset"; r.dout = 8'sd0; r.ovf = 1'b0; r.emp = 1'b1; r.ful = 1'b0;
    chk_all(r);
    @(negedge clk); rst_n = 1'b1;

    op("pop_empty", POP,  0,    0, 0, 1, 0);
    op("push5",     PUSH, 5,    0, 0, 0, 0);
    op("push-3",    PUSH, -3,   0, 0, 0, 0);
    op("pop-3",     POP,  0,   -3, 0, 0, 0);
    op("pop5",      POP,  0,    5, 0, 1, 0);
    op("push10",    PUSH, 10,   5, 0, 0, 0);
    op("push20",    PUSH, 20,   5, 0, 0, 0);
    op("add30",     ADD,  0,   30, 0, 0, 0);
    op("push120",   PUSH, 120, 30, 0, 0, 0);
    op("push100",   PUSH, 100, 30, 0, 0, 0);
    op("add_ovf",   ADD,  0,  -36, 1, 0, 0);
    op("pop100",    POP,  0,  100, 0, 0, 0);
    op("pop120",    POP,  0,  120, 0, 0, 0);
    op("pop20",     POP,  0,   20, 0, 0, 0);
    op("pop10",     POP,  0,   10, 0, 1, 0);

    op("push-4",    PUSH, -4,  10, 0, 0, 0);
    op("push7",     PUSH, 7,   10, 0, 0, 0);
    op("mul-28",    MUL,  0,  -28, 0, 0, 0);
    op("push16a",   PUSH, 16, -28, 0, 0, 0);
    op("push16b",   PUSH, 16, -28, 0, 0, 0);
    op("mul_ovf",   MUL,  0,    0, 1, 0, 0);
    op("pop16a",    POP,  0,   16, 0, 0, 0);
    op("pop16b",    POP,  0,   16, 0, 0, 0);
    op("pop7",      POP,  0,    7, 0, 0, 0);
    op("pop-4",     POP,  0,   -4, 0, 1, 0);

    for (int i = 1; i <= 6; i++) op("fill", PUSH, i, -4, 0, 0, 0);
    op("push100a",  PUSH, 100, -4, 0, 0, 0);
    op("push100b",  PUSH, 100, -4, 0, 0, 1);
    op("add_full",  ADD,  0,  -56, 1, 0, 1);
    op("push_full", PUSH, 99, -56, 0, 0, 1);
    op("pop_top",   POP,  0,  100, 0, 0, 0);
    op("pop_100b",  POP,  0,  100, 0, 0, 0);
    for (int i = 6; i >= 1; i--) op("drain", POP, 0, i, 0, (i == 1), 0);

    op("push42",    PUSH, 42,   1, 0, 0, 0);
    op("add_one",   ADD,  0,    1, 0, 0, 0);
    op("mul_one",   MUL,  0,    1, 0, 0, 0);
    op("nop_x",     3'bxxx, 0,  1, 0, 0, 0);
    op("nop000",    3'b000, 0,  1, 0, 0, 0);
    op("nop011",    3'b011, 0,  1, 0, 0, 0);
    op("pop42",     POP,  0,   42, 0, 1, 0);
    op("push2",     PUSH, 2,   42, 0, 0, 0);
    op("push3",     PUSH, 3,   42, 0, 0, 0);
    op("push4",     PUSH, 4,   42, 0, 0, 0);

    @(negedge clk);
    opcode = 3'b000;
    #2;
    rst_n = 1'b0;
    #1;
    r.name = "async_rst"; r.dout = 8'sd0; r.ovf = 1'b0; r.emp = 1'b1; r.ful = 1'b0;
    chk_all(r);
    @(negedge clk); rst_n = 1'b1;
    op("pop_after_rst", POP,  0, 0, 0, 1, 0);
    op("push9",         PUSH, 9, 0, 0, 0, 0);
    op("add_after_rst", ADD,  0, 0, 0, 0, 0);

    @(negedge clk); opcode = 3'b000;
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
